// File: rtl/alu_secuencial.sv
// 4-bit sequential ALU: one-cycle ops via EXEC, shift-add multiply via MUL (4 cycles).
// Latency: done pulse 2 edges after start (EXEC) or 5 edges after start (MUL); start ignored while busy.
module alu_secuencial (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic [3:0] iA,
  input  logic [3:0] iB,
  input  logic [3:0] iOpcode,
  output logic [3:0] oResult,
  output logic [4:0] oFlags,
  output logic       oBusy,
  output logic       oDone
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  localparam logic [3:0] OP_SUB = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_ADD = 4'b1100;

  state_t     state;
  logic [3:0] opA, opB, opCode;
  logic [1:0] iterCnt;
  logic [7:0] acc;

  logic [7:0] mulAddend, accNext;
  logic [3:0] aluRes, diff, mulRes;
  logic [4:0] sum5, execFlags, mulFlags;
  logic       cFlag, nFlag, vFlag;

  // One multiplier bit per MUL cycle, selected by the iteration counter.
  always_comb begin
    mulAddend = opB[iterCnt] ? ({4'b0000, opA} << iterCnt) : 8'd0;
    accNext   = acc + mulAddend;
    mulRes    = accNext[3:0];
    mulFlags  = {^mulRes, 1'b0, mulRes[3], accNext[7:4] != 4'd0, mulRes == 4'd0};
  end

  always_comb begin
    sum5   = {1'b0, opA} + {1'b0, opB};
    diff   = opA - opB;
    aluRes = 4'd0;
    cFlag  = 1'b0;
    vFlag  = 1'b0;
    case (opCode)
      OP_SUB: begin
        aluRes = diff;
        vFlag  = (opA[3] != opB[3]) && (diff[3] != opA[3]);
      end
      OP_ADD: begin
        aluRes = sum5[3:0];
        cFlag  = sum5[4];
        vFlag  = (opA[3] == opB[3]) && (sum5[3] != opA[3]);
      end
      OP_AND: aluRes = opA & opB;
      OP_OR:  aluRes = opA | opB;
      OP_XOR: aluRes = opA ^ opB;
      OP_NOT: aluRes = ~opA;
      OP_SHL: begin
        aluRes = {opA[2:0], 1'b0};
        cFlag  = opA[3];
      end
      OP_SHR: begin
        aluRes = {1'b0, opA[3:1]};
        cFlag  = opA[0];
      end
      default: aluRes = 4'd0;
    endcase
    // SUB reports unsigned borrow in N so the control unit can compare A and B.
    nFlag     = (opCode == OP_SUB) ? (opA < opB) : aluRes[3];
    execFlags = {^aluRes, vFlag, nFlag, cFlag, aluRes == 4'd0};
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= IDLE;
      opA     <= 4'd0;
      opB     <= 4'd0;
      opCode  <= 4'd0;
      iterCnt <= 2'd0;
      acc     <= 8'd0;
      oResult <= 4'd0;
      oFlags  <= 5'd0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            opA     <= iA;
            opB     <= iB;
            opCode  <= iOpcode;
            iterCnt <= 2'd0;
            acc     <= 8'd0;
            oBusy   <= 1'b1;
            state   <= (iOpcode == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          oResult <= aluRes;
          oFlags  <= execFlags;
          oDone   <= 1'b1;
          state   <= DONE;
        end
        MUL: begin
          acc     <= accNext;
          iterCnt <= iterCnt + 2'd1;
          if (iterCnt == 2'd3) begin
            oResult <= mulRes;
            oFlags  <= mulFlags;
            oDone   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          oDone <= 1'b0;
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed bench for alu_secuencial: per-feature tasks with inline expected-value checks.
module tb_alu_secuencial;

  logic       iClk, iRst, iStart;
  logic [3:0] iA, iB, iOpcode;
  logic [3:0] oResult;
  logic [4:0] oFlags;
  logic       oBusy, oDone;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [3:0] a, b, op, res;
    logic [4:0] flags;
    int         lat;
  } vec_t;

  alu_secuencial dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iA(iA), .iB(iB), .iOpcode(iOpcode),
    .oResult(oResult), .oFlags(oFlags), .oBusy(oBusy), .oDone(oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Starts an op from IDLE, scrambles inputs after the start edge, and waits (bounded) for oDone.
  // lat = edges after the start edge until oDone is seen, -1 on timeout; one further edge returns to IDLE.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        output int lat, output logic doneAfter);
    iA = a; iB = b; iOpcode = op; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0; iA = ~a; iB = ~b; iOpcode = ~op;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge iClk); #1;
      if (oDone) begin
        lat = i;
        break;
      end
    end
    @(posedge iClk); #1;
    doneAfter = oDone;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iStart = 1'b0; iA = 4'h0; iB = 4'h0; iOpcode = 4'h0;
    repeat (2) @(posedge iClk);
    #1;
    nChecks++; if (oResult !== 4'h0) begin nFails++; $display("FAIL reset_result got %b want 0000", oResult); end
    nChecks++; if (oFlags !== 5'b00000) begin nFails++; $display("FAIL reset_flags got %b want 00000", oFlags); end
    nChecks++; if (oBusy !== 1'b0) begin nFails++; $display("FAIL reset_busy got %b want 0", oBusy); end
    nChecks++; if (oDone !== 1'b0) begin nFails++; $display("FAIL reset_done got %b want 0", oDone); end
    iRst = 1'b0;
  endtask

  task automatic check_vectors(input string name, input vec_t vecs[$]);
    int lat;
    logic doneAfter;
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat, doneAfter);
      nChecks++; if (lat != vecs[i].lat) begin nFails++; $display("FAIL %s[%0d]_latency got %0d want %0d", name, i, lat, vecs[i].lat); end
      nChecks++; if (oResult !== vecs[i].res) begin nFails++; $display("FAIL %s[%0d]_result got %b want %b", name, i, oResult, vecs[i].res); end
      nChecks++; if (oFlags !== vecs[i].flags) begin nFails++; $display("FAIL %s[%0d]_flags got %b want %b", name, i, oFlags, vecs[i].flags); end
      nChecks++; if (doneAfter !== 1'b0) begin nFails++; $display("FAIL %s[%0d]_done_width got %b want 0", name, i, doneAfter); end
    end
  endtask

  // Flags column is {P,V,N,C,Z}.
  task automatic test_arith();
    vec_t v[$];
    v.push_back('{4'h1, 4'h2, 4'b0000, 4'hF, 5'b00100, 1}); // SUB A<B
    v.push_back('{4'h2, 4'h2, 4'b0000, 4'h0, 5'b00001, 1}); // SUB A==B
    v.push_back('{4'h5, 4'h3, 4'b0000, 4'h2, 5'b10000, 1}); // SUB A>B
    v.push_back('{4'h8, 4'h1, 4'b0000, 4'h7, 5'b11000, 1}); // SUB signed overflow
    v.push_back('{4'h3, 4'h5, 4'b0000, 4'hE, 5'b10100, 1});
    v.push_back('{4'hF, 4'h1, 4'b1100, 4'h0, 5'b00011, 1}); // ADD wrap with carry
    v.push_back('{4'h7, 4'h1, 4'b1100, 4'h8, 5'b11100, 1}); // ADD signed overflow
    check_vectors("arith", v);
  endtask

  task automatic test_logic();
    vec_t v[$];
    v.push_back('{4'hC, 4'hA, 4'b0001, 4'h8, 5'b10100, 1});
    v.push_back('{4'h5, 4'hA, 4'b0010, 4'hF, 5'b00100, 1});
    v.push_back('{4'hF, 4'h5, 4'b0011, 4'hA, 5'b00100, 1});
    v.push_back('{4'h3, 4'h0, 4'b0100, 4'hC, 5'b00100, 1});
    v.push_back('{4'h9, 4'h0, 4'b0101, 4'h2, 5'b10010, 1}); // SHL carry from A[3]
    v.push_back('{4'h4, 4'h0, 4'b0101, 4'h8, 5'b10100, 1});
    v.push_back('{4'h9, 4'h0, 4'b0110, 4'h4, 5'b10010, 1}); // SHR carry from A[0]
    v.push_back('{4'h8, 4'h0, 4'b0110, 4'h4, 5'b10000, 1});
    v.push_back('{4'hF, 4'hF, 4'b0111, 4'h0, 5'b00001, 1}); // undefined opcodes
    v.push_back('{4'hF, 4'hF, 4'b1111, 4'h0, 5'b00001, 1});
    check_vectors("logic", v);
  endtask

  task automatic test_mul();
    vec_t v[$];
    v.push_back('{4'h3, 4'h5, 4'b1000, 4'hF, 5'b00100, 4});
    v.push_back('{4'h7, 4'h3, 4'b1000, 4'h5, 5'b00010, 4});
    v.push_back('{4'hF, 4'hF, 4'b1000, 4'h1, 5'b10010, 4});
    v.push_back('{4'h0, 4'h9, 4'b1000, 4'h0, 5'b00001, 4});
    check_vectors("mul", v);
  endtask

  task automatic test_hold();
    int lat;
    logic doneAfter;
    run_op(4'h7, 4'h1, 4'b1100, lat, doneAfter);
    iA = 4'h1; iB = 4'h2; iOpcode = 4'b0000;
    repeat (5) @(posedge iClk);
    #1;
    nChecks++; if (oResult !== 4'h8) begin nFails++; $display("FAIL hold_result got %b want 1000", oResult); end
    nChecks++; if (oFlags !== 5'b11100) begin nFails++; $display("FAIL hold_flags got %b want 11100", oFlags); end
    nChecks++; if (oBusy !== 1'b0) begin nFails++; $display("FAIL hold_busy got %b want 0", oBusy); end
  endtask

  task automatic test_start_held();
    int dones = 0;
    int doneAt = -1;
    logic busy5, busy6;
    iA = 4'h3; iB = 4'h5; iOpcode = 4'b1000; iStart = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      @(posedge iClk); #1;
      if (oDone && i <= 5) begin dones++; doneAt = i; end
      if (i == 5) busy5 = oBusy;
      if (i == 6) busy6 = oBusy;
    end
    iStart = 1'b0;
    nChecks++; if (dones != 1) begin nFails++; $display("FAIL held_done_count got %0d want 1", dones); end
    nChecks++; if (doneAt != 4) begin nFails++; $display("FAIL held_done_edge got %0d want 4", doneAt); end
    nChecks++; if (busy5 !== 1'b0) begin nFails++; $display("FAIL held_idle_busy got %b want 0", busy5); end
    nChecks++; if (busy6 !== 1'b1) begin nFails++; $display("FAIL held_restart_busy got %b want 1", busy6); end
    repeat (6) @(posedge iClk);
    #1;
    nChecks++; if (oResult !== 4'hF) begin nFails++; $display("FAIL held_second_result got %b want 1111", oResult); end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    int lat;
    logic doneAfter;
    run_op(4'h7, 4'h3, 4'b1000, lat, doneAfter);
    iA = 4'h3; iB = 4'h5; iOpcode = 4'b1000; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    @(posedge iClk); #1;
    iRst = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    nChecks++; if (oDone !== 1'b0) begin nFails++; $display("FAIL abort_done got %b want 0", oDone); end
    nChecks++; if (oBusy !== 1'b0) begin nFails++; $display("FAIL abort_busy got %b want 0", oBusy); end
    nChecks++; if (oResult !== 4'h0) begin nFails++; $display("FAIL abort_result got %b want 0000", oResult); end
    nChecks++; if (oFlags !== 5'b00000) begin nFails++; $display("FAIL abort_flags got %b want 00000", oFlags); end
    for (int i = 0; i < 6; i++) begin
      @(posedge iClk); #1;
      if (oDone) dones++;
    end
    nChecks++; if (dones != 0) begin nFails++; $display("FAIL abort_late_done got %0d want 0", dones); end
    run_op(4'h1, 4'h1, 4'b1100, lat, doneAfter);
    nChecks++; if (lat != 1) begin nFails++; $display("FAIL post_reset_latency got %0d want 1", lat); end
    nChecks++; if (oResult !== 4'h2) begin nFails++; $display("FAIL post_reset_result got %b want 0010", oResult); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_mul();
    test_hold();
    test_start_held();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
